icache_direct_mapped: RTL and testbench

//  Direct-mapped, read-only instruction cache between the CPU fetch stage and the 128-bit

---
 rtl/icache_direct_mapped_if.sv | 34 +++
 rtl/icache_direct_mapped.sv | 163 ++++++++++++++++
 tb/tb_icache_direct_mapped.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/icache_direct_mapped_if.sv
// Bus bundle for icache_direct_mapped: CPU fetch side and 128-bit instruction
// memory side. The slave modport is the cache's view; the master modport is the
// environment (CPU fetch stage plus instruction memory).
// Optional statistics outputs exist only when ICACHE_STATS_EN is defined.
interface icache_direct_mapped_if;
  logic         cpu_read;
  logic [31:0]  cpu_address;
  logic [31:0]  cpu_instruction;
  logic         cpu_busywait;
  logic         mem_read;
  logic [27:0]  mem_address;
  logic [127:0] mem_readdata;
  logic         mem_busywait;
`ifdef ICACHE_STATS_EN
  logic [31:0]  hit_count;
  logic [31:0]  miss_count;
`endif

  modport slave (
    input  cpu_read, cpu_address, mem_readdata, mem_busywait,
    output cpu_instruction, cpu_busywait, mem_read, mem_address
`ifdef ICACHE_STATS_EN
    , output hit_count, miss_count
`endif
  );

  modport master (
    output cpu_read, cpu_address, mem_readdata, mem_busywait,
    input  cpu_instruction, cpu_busywait, mem_read, mem_address
`ifdef ICACHE_STATS_EN
    , input hit_count, miss_count
`endif
  );
endinterface

// File: rtl/icache_direct_mapped.sv
// Direct-mapped read-only instruction cache. Hits return the selected 32-bit word
// in the same cycle; misses fetch a 16-byte block from instruction memory and
// refill one line (IDLE -> MEM_READ -> UPDATE -> IDLE).
// Optional feature: define ICACHE_STATS_EN to add hit_count / miss_count outputs.
module icache_direct_mapped #(
  parameter int INDEX_BITS = 3,
  parameter int TAG_BITS   = 28 - INDEX_BITS
) (
  input logic                  clock,
  input logic                  reset,
  icache_direct_mapped_if.slave bus
);

  localparam int LINES = 2 ** INDEX_BITS;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MEM_READ = 2'd1,
    UPDATE   = 2'd2
  } state_t;

  state_t state_q, state_d;

  // Line storage: valid bits are reset, tags and data are not.
  logic [LINES-1:0]    valid_q;
  logic [TAG_BITS-1:0] tag_q  [LINES];
  logic [127:0]        data_q [LINES];

  // Block address captured when the miss is accepted; the refill uses it.
  logic [27:0] blk_q, blk_d;

  // Address decode of the current fetch request.
  logic [INDEX_BITS-1:0] req_idx;
  logic [TAG_BITS-1:0]   req_tag;
  logic [1:0]            req_word;
  logic [1:0]            unused_byte_offset;

  assign req_idx            = bus.cpu_address[3+INDEX_BITS:4];
  assign req_tag            = bus.cpu_address[31:4+INDEX_BITS];
  assign req_word           = bus.cpu_address[3:2];
  assign unused_byte_offset = bus.cpu_address[1:0];

  // Refill target comes from the captured block address, not the live bus.
  logic [INDEX_BITS-1:0] fill_idx;
  logic [TAG_BITS-1:0]   fill_tag;

  assign fill_idx = blk_q[INDEX_BITS-1:0];
  assign fill_tag = blk_q[27:INDEX_BITS];

  logic hit;
  assign hit = bus.cpu_read & valid_q[req_idx] & (tag_q[req_idx] == req_tag);

  // Word select within the addressed line; zero whenever the fetch is not a hit.
  logic [127:0] hit_line;
  logic [31:0]  line_words [4];

  assign hit_line = data_q[req_idx];

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_word
      assign line_words[gi] = hit_line[32*gi +: 32];
    end
  endgenerate

  assign bus.cpu_instruction = hit ? line_words[req_word] : 32'h0;

  logic busy;
  logic mem_read_c;
  logic [27:0] mem_address_c;
  logic fill_en;

  // Next-state and output decode for the miss-handling FSM.
  always_comb begin
    state_d       = state_q;
    blk_d         = blk_q;
    busy          = 1'b0;
    mem_read_c    = 1'b0;
    mem_address_c = 28'h0;
    fill_en       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.cpu_read && !hit) begin
          busy    = 1'b1;
          blk_d   = bus.cpu_address[31:4];
          state_d = MEM_READ;
        end
      end
      MEM_READ: begin
        busy          = 1'b1;
        mem_read_c    = 1'b1;
        mem_address_c = blk_q;
        if (!bus.mem_busywait) begin
          state_d = UPDATE;
        end
      end
      UPDATE: begin
        busy    = 1'b1;
        fill_en = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // While reset is held the stall output is forced low even if a miss is requested.
  assign bus.cpu_busywait = busy & ~reset;
  assign bus.mem_read     = mem_read_c;
  assign bus.mem_address  = mem_address_c;

  // State and captured block address; reset aborts any fill in progress.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      blk_q   <= 28'h0;
    end else begin
      state_q <= state_d;
      blk_q   <= blk_d;
    end
  end

  // Valid bits: cleared by reset, set when a line is refilled.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
    end else if (fill_en) begin
      valid_q[fill_idx] <= 1'b1;
    end
  end

  // Tag and data arrays: written only in UPDATE, unconditionally replacing the line.
  always_ff @(posedge clock) begin
    if (fill_en) begin
      tag_q[fill_idx]  <= fill_tag;
      data_q[fill_idx] <= bus.mem_readdata;
    end
  end

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count_q;
  logic [31:0] miss_count_q;

  // Hit and miss counters; both wrap naturally at 2**32.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hit_count_q  <= 32'h0;
      miss_count_q <= 32'h0;
    end else begin
      if (state_q == IDLE && hit) begin
        hit_count_q <= hit_count_q + 32'd1;
      end
      if (state_q == IDLE && state_d == MEM_READ) begin
        miss_count_q <= miss_count_q + 32'd1;
      end
    end
  end

  assign bus.hit_count  = hit_count_q;
  assign bus.miss_count = miss_count_q;
`endif

endmodule

// File: tb/tb_icache_direct_mapped.sv
// Randomized self-checking bench for icache_direct_mapped. A behavioural model
// tracks which block each line holds; memory content is a fixed function of the
// byte address, so every expected instruction follows directly from the address.
module tb_icache_direct_mapped;

  localparam logic [31:0] PATTERN = 32'h5A5A_C3C3;

  logic clock;
  logic reset;

  icache_direct_mapped_if bus ();

  icache_direct_mapped #(.INDEX_BITS(3), .TAG_BITS(25)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Instruction memory: word at byte address a is {a[31:2],2'b00} ^ PATTERN.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[31:2], 2'b00} ^ PATTERN;
  endfunction

  function automatic logic [127:0] mem_block(input logic [27:0] blk);
    logic [127:0] b;
    for (int w = 0; w < 4; w++) begin
      b[32*w +: 32] = mem_word({blk, 4'h0} + 32'(4 * w));
    end
    return b;
  endfunction

  // Memory responder: holds data for the last requested block, and stalls the
  // first wait_cfg cycles of each read request.
  int          wait_cfg;
  int          mr_cycles;
  logic [27:0] lat_blk;

  always @(posedge clock) begin
    mr_cycles <= bus.mem_read ? mr_cycles + 1 : 0;
    if (bus.mem_read) lat_blk <= bus.mem_address;
  end

  assign bus.mem_busywait = bus.mem_read && (mr_cycles < wait_cfg);
  assign bus.mem_readdata = mem_block(lat_blk);

  // Reference model: per index, whether it holds a block and which one.
  bit          line_ok  [8];
  logic [27:0] line_blk [8];
  int unsigned model_hits;
  int unsigned model_misses;

  int checks_total;
  int checks_passed;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_total++;
    if (got === exp) checks_passed++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) line_ok[i] = 1'b0;
    model_hits   = 0;
    model_misses = 0;
  endtask

  // One fetch transaction, ending one cycle after the instruction is delivered.
  task automatic fetch(input logic [31:0] a, input int waitc, input bit drop);
    logic [27:0] blk;
    int          idx;
    blk = a[31:4];
    idx = int'(blk[2:0]);
    wait_cfg        = waitc;
    bus.cpu_read    = 1'b1;
    bus.cpu_address = a;
    @(negedge clock);
    if (line_ok[idx] && line_blk[idx] == blk) begin
      $display("fetch %h hit", a);
      check_value("hit_busywait", 32'(bus.cpu_busywait), 32'd0);
      check_value("hit_instr", bus.cpu_instruction, mem_word(a));
      check_value("hit_mem_read", 32'(bus.mem_read), 32'd0);
      model_hits++;
    end else begin
      $display("fetch %h miss wait=%0d drop=%0d", a, waitc, drop);
      model_misses++;
      check_value("miss_busywait", 32'(bus.cpu_busywait), 32'd1);
      check_value("miss_instr", bus.cpu_instruction, 32'd0);
      check_value("miss_mem_read_idle", 32'(bus.mem_read), 32'd0);
      for (int n = 1; n <= waitc + 1; n++) begin
        @(posedge clock); #1;
        if (drop && n == 1) bus.cpu_read = 1'b0;
        @(negedge clock);
        check_value("memrd_busywait", 32'(bus.cpu_busywait), 32'd1);
        check_value("memrd_mem_read", 32'(bus.mem_read), 32'd1);
        check_value("memrd_mem_address", 32'(bus.mem_address), 32'(blk));
      end
      @(negedge clock);
      check_value("update_busywait", 32'(bus.cpu_busywait), 32'd1);
      check_value("update_mem_read", 32'(bus.mem_read), 32'd0);
      @(negedge clock);
      line_ok[idx]  = 1'b1;
      line_blk[idx] = blk;
      check_value("done_busywait", 32'(bus.cpu_busywait), 32'd0);
      check_value("done_mem_read", 32'(bus.mem_read), 32'd0);
      if (drop) begin
        check_value("done_instr_dropped", bus.cpu_instruction, 32'd0);
      end else begin
        check_value("done_instr", bus.cpu_instruction, mem_word(a));
        model_hits++;
      end
    end
    @(posedge clock); #1;
  endtask

  task automatic idle_cycle();
    bus.cpu_read    = 1'b0;
    bus.cpu_address = $urandom;
    @(negedge clock);
    $display("idle addr=%h", bus.cpu_address);
    check_value("idle_busywait", 32'(bus.cpu_busywait), 32'd0);
    check_value("idle_instr", bus.cpu_instruction, 32'd0);
    check_value("idle_mem_read", 32'(bus.mem_read), 32'd0);
    @(posedge clock); #1;
  endtask

  initial begin
    logic [31:0] a;
    checks_total    = 0;
    checks_passed   = 0;
    wait_cfg        = 0;
    reset           = 1'b1;
    bus.cpu_read    = 1'b0;
    bus.cpu_address = 32'h0;
    model_reset();
    repeat (2) @(negedge clock);
    check_value("rst_busywait", 32'(bus.cpu_busywait), 32'd0);
    check_value("rst_mem_read", 32'(bus.mem_read), 32'd0);
    check_value("rst_mem_address", 32'(bus.mem_address), 32'd0);
    check_value("rst_instr", bus.cpu_instruction, 32'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock); #1;

    // Cold fill of block 0, then the remaining words of that block.
    fetch(32'h0000_0000, 0, 1'b0);
    fetch(32'h0000_0004, 0, 1'b0);
    fetch(32'h0000_0008, 0, 1'b0);
    fetch(32'h0000_000C, 0, 1'b0);
    // Same index, other tag: replaces line 0, so block 0 misses again.
    fetch(32'h0000_0080, 0, 1'b0);
    fetch(32'h0000_0000, 0, 1'b0);
`ifdef ICACHE_STATS_EN
    check_value("stats_miss", bus.miss_count, model_misses);
    check_value("stats_hit", bus.hit_count, model_hits);
`endif
    // Slow memory, then a request dropped mid-miss.
    fetch(32'h0000_0110, 5, 1'b0);
    fetch(32'h0000_0114, 0, 1'b0);
    fetch(32'h0000_0200, 1, 1'b1);
    fetch(32'h0000_0207, 0, 1'b0);

    // Reset pulse while in MEM_READ aborts the fill.
    bus.cpu_read    = 1'b1;
    bus.cpu_address = 32'h0000_0330;
    wait_cfg        = 3;
    @(posedge clock); #2;
    check_value("pre_rst_mem_read", 32'(bus.mem_read), 32'd1);
    reset = 1'b1;
    #1;
    $display("reset pulse during MEM_READ");
    check_value("async_rst_mem_read", 32'(bus.mem_read), 32'd0);
    check_value("async_rst_busywait", 32'(bus.cpu_busywait), 32'd0);
    model_reset();
    @(posedge clock); #1;
    reset = 1'b0;
    fetch(32'h0000_0330, 0, 1'b0);
    fetch(32'h0000_0000, 0, 1'b0);

    // Randomized traffic over a small block set so hits and conflicts both occur.
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        idle_cycle();
      end else begin
        a = 32'($urandom_range(0, 31)) << 4;
        a = a | (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
        if ($urandom_range(0, 3) == 0) a = a | 32'hF000_0000;
        fetch(a, $urandom_range(0, 3), ($urandom_range(0, 7) == 0));
      end
    end
`ifdef ICACHE_STATS_EN
    check_value("stats_miss_end", bus.miss_count, model_misses);
    check_value("stats_hit_end", bus.hit_count, model_hits);
`endif

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
